// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the SR latch command driver.
//   state_e    : driver FSM encoding (idle / pulse / guard gap)
//   OP_SET     : command opcode that drives S
//   OP_RESET   : command opcode that drives R
//   op_to_sr() : maps an opcode onto the {s, r} drive pair
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPulse = 2'b01,
    StGap   = 2'b10
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Exactly one of s/r is set, so the pair can never be 2'b11.
  function automatic logic [1:0] op_to_sr(input logic op);
    return (op == OP_SET) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sr_cmd_timer.sv
// Loadable down-counter with a zero flag; times the pulse and gap phases.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset (count -> 0)
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero
module sr_cmd_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sr_cmd_driver.sv
// Upstream driver for the SR latch stage. Turns set/reset commands taken on a
// valid/ready handshake into registered S/R pulses of PULSE_W cycles, each
// followed by GAP_W idle cycles; S and R are never high together. At the end
// of the gap the latch feedback is compared with the commanded value and a
// sticky error is raised on mismatch.
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   req_valid, req_op    : command handshake (req_op 1 = set, 0 = reset)
//   req_ready            : command accepted when valid && ready at an edge
//   s, r                 : registered latch drives
//   q_fb                 : latch output fed back for checking
//   busy                 : pulse or gap in progress
//   exp_q                : latch value expected after the last completed command
//   err, err_clr         : sticky mismatch flag and its clear (set wins)
// Build option: define SR_CMD_DRIVER_SKID_EN to add a one-entry command buffer
// so a command can be accepted during PULSE/GAP and start back-to-back.
module sr_cmd_driver
  import sr_cmd_pkg::*;
#(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_op,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic exp_q,
  output logic err,
  input  logic err_clr
);

  localparam int unsigned MaxW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CntW = $clog2(MaxW + 1);
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_W - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_W - 1);

  state_e state_q, state_d;
  logic s_q, s_d, r_q, r_d;
  logic op_q, op_d;
  logic exp_val_q, exp_val_d;
  logic err_q, err_d;

  logic            tmr_load, tmr_dec, tmr_zero;
  logic [CntW-1:0] tmr_load_val;
  logic            start, start_op;

`ifdef SR_CMD_DRIVER_SKID_EN
  logic buf_valid_q, buf_valid_d, buf_op_q, buf_op_d;
  logic accept;

  assign req_ready = ~buf_valid_q;
  assign accept    = req_valid & req_ready;
`else
  assign req_ready = (state_q == StIdle);
`endif

  sr_cmd_timer #(
    .Width(CntW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    s_d          = 1'b0;
    r_d          = 1'b0;
    op_d         = op_q;
    exp_val_d    = exp_val_q;
    err_d        = err_clr ? 1'b0 : err_q;
    tmr_load     = 1'b0;
    tmr_load_val = PulseLoad;
    tmr_dec      = 1'b0;
    start        = 1'b0;
    start_op     = req_op;
`ifdef SR_CMD_DRIVER_SKID_EN
    buf_valid_d  = buf_valid_q;
    buf_op_d     = buf_op_q;
`endif

    unique case (state_q)
      // The skid buffer is always empty in idle, so ready is high in both builds.
      StIdle: start = req_valid;
      StPulse: begin
        if (tmr_zero) begin
          state_d      = StGap;
          tmr_load     = 1'b1;
          tmr_load_val = GapLoad;
        end else begin
          s_d     = s_q;
          r_d     = r_q;
          tmr_dec = 1'b1;
        end
`ifdef SR_CMD_DRIVER_SKID_EN
        if (accept) begin
          buf_valid_d = 1'b1;
          buf_op_d    = req_op;
        end
`endif
      end
      StGap: begin
        if (tmr_zero) begin
          if (q_fb != op_q) err_d = 1'b1;
          exp_val_d = op_q;
          state_d   = StIdle;
`ifdef SR_CMD_DRIVER_SKID_EN
          // Chain straight into the next pulse: buffered command first,
          // otherwise one arriving on this very edge.
          if (buf_valid_q) begin
            start       = 1'b1;
            start_op    = buf_op_q;
            buf_valid_d = 1'b0;
          end else begin
            start = accept;
          end
`endif
        end else begin
          tmr_dec = 1'b1;
`ifdef SR_CMD_DRIVER_SKID_EN
          if (accept) begin
            buf_valid_d = 1'b1;
            buf_op_d    = req_op;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      op_d         = start_op;
      {s_d, r_d}   = op_to_sr(start_op);
      tmr_load     = 1'b1;
      tmr_load_val = PulseLoad;
      state_d      = StPulse;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      op_q      <= OP_RESET;
      exp_val_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      r_q       <= r_d;
      op_q      <= op_d;
      exp_val_q <= exp_val_d;
      err_q     <= err_d;
    end
  end

`ifdef SR_CMD_DRIVER_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_op_q    <= OP_RESET;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_op_q    <= buf_op_d;
    end
  end
`endif

  assign s     = s_q;
  assign r     = r_q;
  assign busy  = (state_q != StIdle);
  assign exp_q = exp_val_q;
  assign err   = err_q;

endmodule
